ext_ctrl_event_seq: RTL and testbench

EXT_CTRL_EVENT_SEQ -- requirements
Module: ext_ctrl_event_seq

---
 rtl/ext_ctrl_event_pkg.sv | 61 ++++++
 rtl/ext_ctrl_event_seq_if.sv | 12 +
 rtl/ext_ctrl_event_fifo.sv | 79 +++++++
 rtl/ext_ctrl_event_seq.sv | 150 +++++++++++++++
 tb/tb_ext_ctrl_event_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_ctrl_event_pkg.sv
// Shared types and constants for the PIO edge-event sequencer.
package ext_ctrl_event_pkg;

    localparam int unsigned EVT_WIDTH = 8;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRdEdge,
        StWaitEdge,
        StClrEdge,
        StRdData,
        StWaitData,
        StPush
    } state_e;

    typedef struct packed {
        logic [1:0]  address;
        logic        chipselect;
        logic        write_n;
        logic [31:0] writedata;
    } pio_bus_t;

    // Bus cycle driven while the sequencer sits in a given state.
    function automatic pio_bus_t bus_for_state(input state_e st, input logic [3:0] mask);
        pio_bus_t b;
        b.address    = 2'd0;
        b.chipselect = 1'b0;
        b.write_n    = 1'b1;
        b.writedata  = 32'h0;
        case (st)
            StInit: begin
                b.address    = ADDR_MASK;
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = {28'h0, mask};
            end
            StRdEdge: begin
                b.address    = ADDR_EDGE;
                b.chipselect = 1'b1;
            end
            StClrEdge: begin
                b.address    = ADDR_EDGE;
                b.chipselect = 1'b1;
                b.write_n    = 1'b0;
                b.writedata  = 32'hF;
            end
            StRdData: begin
                b.address    = ADDR_DATA;
                b.chipselect = 1'b1;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ext_ctrl_event_seq_if.sv
// Ready/valid event stream carrying {data, edges} records.
interface ext_ctrl_event_seq_if;
    import ext_ctrl_event_pkg::*;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [EVT_WIDTH-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/ext_ctrl_event_fifo.sv
// Synchronous event FIFO with a registered head entry.
module ext_ctrl_event_fifo
    import ext_ctrl_event_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [EVT_WIDTH-1:0] push_data,
    output logic                 full,
    ext_ctrl_event_seq_if.master evt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [EVT_WIDTH-1:0] head_q, head_d;
    logic [EVT_WIDTH-1:0] mem_q [DEPTH];
    logic                 push_ok;
    logic                 pop;
    logic                 empty_after_pop;

    // Full is judged on the pre-pop occupancy, so push+pop when full drops the push.
    assign full          = (count_q == (AW + 1)'(DEPTH));
    assign push_ok       = push & ~full;
    assign pop           = evt.evt_valid & evt.evt_ready;
    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_data  = head_q;

    // Pointer/occupancy update and next head selection.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        empty_after_pop = (count_q == '0) | (pop & (count_q == (AW + 1)'(1)));
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (count_d != '0) begin
            // A push into an otherwise empty FIFO bypasses straight to the head.
            head_d = (push_ok && empty_after_pop) ? push_data : mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control state, cleared asynchronously to discard queued events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/ext_ctrl_event_seq.sv
// Sequencer that services PIO edge interrupts and queues {data, edges} events.
module ext_ctrl_event_seq
    import ext_ctrl_event_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  INIT_MASK  = 4'hF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           cfg_mask,
    input  logic                 cfg_load,
    output logic [1:0]           pio_address,
    output logic                 pio_chipselect,
    output logic                 pio_write_n,
    output logic [31:0]          pio_writedata,
    input  logic [31:0]          pio_readdata,
    input  logic                 pio_irq,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [EVT_WIDTH-1:0] evt_data,
    output logic [7:0]           ovf_count,
    output logic                 busy
);

    state_e     state_q, state_d;
    logic       started_q, started_d;
    logic [3:0] mask_q, mask_d;
    logic       pend_q, pend_d;
    logic [3:0] pend_mask_q, pend_mask_d;
    logic [3:0] edges_q, edges_d;
    logic [3:0] data_q, data_d;
    logic [7:0] ovf_q, ovf_d;
    logic       busy_q, busy_d;
    pio_bus_t   bus_q, bus_d;
    logic       push_evt;
    logic       fifo_full;
    logic       load_req;
    logic [3:0] load_mask;
    logic       unused_rd;

    assign unused_rd = ^pio_readdata[31:4];

    ext_ctrl_event_seq_if evt_if ();

    assign evt_if.evt_ready = evt_ready;
    assign evt_valid        = evt_if.evt_valid;
    assign evt_data         = evt_if.evt_data;

    ext_ctrl_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_evt),
        .push_data ({data_q, edges_q}),
        .full      (fifo_full),
        .evt       (evt_if)
    );

    // Next state, captured register values and the bus cycle for the next state.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        pend_mask_d = pend_mask_q;
        edges_d     = edges_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        push_evt    = 1'b0;
        started_d   = 1'b1;
        load_req    = pend_q | cfg_load;
        load_mask   = cfg_load ? cfg_mask : pend_mask_q;

        if (cfg_load) begin
            pend_d      = 1'b1;
            pend_mask_d = cfg_mask;
        end

        case (state_q)
            // Held for one cycle after reset release so the mask write is visible.
            StInit: if (started_q) state_d = StIdle;
            StIdle: begin
                if (load_req) begin
                    mask_d  = load_mask;
                    pend_d  = 1'b0;
                    state_d = StInit;
                end else if (pio_irq) begin
                    state_d = StRdEdge;
                end
            end
            StRdEdge: state_d = StWaitEdge;
            StWaitEdge: begin
                edges_d = pio_readdata[3:0] & mask_q;
                state_d = (edges_d == 4'h0) ? StIdle : StClrEdge;
            end
            StClrEdge: state_d = StRdData;
            StRdData:  state_d = StWaitData;
            StWaitData: begin
                data_d  = pio_readdata[3:0];
                state_d = StPush;
            end
            StPush: begin
                push_evt = 1'b1;
                if (fifo_full && (ovf_q != 8'hFF)) begin
                    ovf_d = ovf_q + 8'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        busy_d = (state_d != StIdle);
        bus_d  = bus_for_state(state_d, mask_d);
    end

    // State and registered outputs; reset leaves the bus idle while parked in INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            started_q   <= 1'b0;
            mask_q      <= INIT_MASK;
            pend_q      <= 1'b0;
            pend_mask_q <= 4'h0;
            edges_q     <= 4'h0;
            data_q      <= 4'h0;
            ovf_q       <= 8'h0;
            busy_q      <= 1'b1;
            bus_q       <= bus_for_state(StIdle, 4'h0);
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            pend_mask_q <= pend_mask_d;
            edges_q     <= edges_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            bus_q       <= bus_d;
        end
    end

    assign pio_address    = bus_q.address;
    assign pio_chipselect = bus_q.chipselect;
    assign pio_write_n    = bus_q.write_n;
    assign pio_writedata  = bus_q.writedata;
    assign ovf_count      = ovf_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ext_ctrl_event_seq.sv
// Self-checking bench for ext_ctrl_event_seq with a small edge-capture PIO model.
module tb_ext_ctrl_event_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  cfg_mask = 4'h0;
    logic        cfg_load = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;
    logic [7:0]  ovf_count;
    logic        busy;
    logic [3:0]  in_port = 4'h0;
    logic        irq_force = 1'b0;
    logic [3:0]  pio_ecap;
    logic [3:0]  pio_mask;
    logic [3:0]  in_prev;

    ext_ctrl_event_seq_if evt_bus ();

    int tests = 0;
    int fails = 0;
    int idle_bad = 0;
    int log_base = 0;
    logic [35:0] bus_log[$];
    logic [35:0] exp_log[$];

    typedef struct {
        logic [3:0] in_val;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    ext_ctrl_event_seq #(
        .FIFO_DEPTH (4),
        .INIT_MASK  (4'hF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_mask       (cfg_mask),
        .cfg_load       (cfg_load),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .pio_irq        (pio_irq),
        .evt_valid      (evt_bus.evt_valid),
        .evt_ready      (evt_bus.evt_ready),
        .evt_data       (evt_bus.evt_data),
        .ovf_count      (ovf_count),
        .busy           (busy)
    );

    // PIO model: rising-edge capture, write-1-to-clear, registered read data.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_ecap     <= 4'h0;
            pio_mask     <= 4'h0;
            pio_readdata <= 32'h0;
            in_prev      <= 4'h0;
        end else begin
            in_prev  <= in_port;
            pio_ecap <= (pio_ecap & ~((pio_chipselect && !pio_write_n && pio_address == 2'd3)
                        ? pio_writedata[3:0] : 4'h0)) | (in_port & ~in_prev);
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask <= pio_writedata[3:0];
            if (pio_chipselect && pio_write_n) begin
                case (pio_address)
                    2'd0:    pio_readdata <= {28'h0, in_port};
                    2'd2:    pio_readdata <= {28'h0, pio_mask};
                    2'd3:    pio_readdata <= {28'h0, pio_ecap};
                    default: pio_readdata <= 32'h0;
                endcase
            end
        end
    end

    assign pio_irq = (|(pio_ecap & pio_mask)) | irq_force;

    function automatic logic [35:0] enc(input logic wr, input logic [1:0] a, input logic [31:0] d);
        return {1'b0, wr, a, wr ? d : 32'h0};
    endfunction

    // Bus transaction log and idle-bus value monitor.
    always @(negedge clk) begin
        if (reset_n && pio_chipselect) bus_log.push_back(enc(!pio_write_n, pio_address, pio_writedata));
        if (!pio_chipselect && (pio_address != 2'd0 || pio_writedata != 32'h0 || !pio_write_n))
            idle_bad++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mark;
        log_base = bus_log.size();
    endtask

    task automatic check_log(input string name);
        int n = bus_log.size() - log_base;
        check({name, "_len"}, 64'(n), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < n; i++)
            check($sformatf("%s_%0d", name, i), 64'(bus_log[log_base + i]), 64'(exp_log[i]));
    endtask

    task automatic one_event(input logic [3:0] v, output bit ok);
        int n;
        ok = 1'b1;
        in_port = v;
        n = 0;
        while (!busy && n < 40) begin tick; n++; end
        if (!busy) ok = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        if (busy) ok = 1'b0;
        in_port = 4'h0;
        tick;
        tick;
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        in_port = 4'h0;
        cfg_load = 1'b0;
        irq_force = 1'b0;
        tick;
        tick;
        mark;
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        tick;
        tick;
        exp_log.delete();
        exp_log.push_back(enc(1'b1, 2'd2, 32'hF));
        check_log(name);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit ok;
        bit all_ok;
        int lat;
        bit irq_seen;

        evt_bus.evt_ready = 1'b1;
        vecs[0] = '{4'h5, 8'h55, 8};
        vecs[1] = '{4'h1, 8'h11, 8};
        vecs[2] = '{4'hA, 8'hAA, 8};
        vecs[3] = '{4'hF, 8'hFF, 8};
        vecs[4] = '{4'h8, 8'h88, 8};

        // Reset state
        tick;
        tick;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_valid", 64'(evt_bus.evt_valid), 64'd0);
        check("rst_data", 64'(evt_bus.evt_data), 64'h0);
        check("rst_ovf", 64'(ovf_count), 64'h0);
        check("rst_bus", enc(!pio_write_n, pio_address, pio_writedata) | 64'(pio_chipselect), 64'h0);

        // First cycle after release writes the mask
        mark;
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        check("init_cs", 64'(pio_chipselect), 64'd1);
        check("init_wr", 64'(enc(!pio_write_n, pio_address, pio_writedata)), 64'(enc(1'b1, 2'd2, 32'hF)));
        tick;
        tick;
        check("init_busy", 64'(busy), 64'd0);
        exp_log.delete();
        exp_log.push_back(enc(1'b1, 2'd2, 32'hF));
        check_log("init_seq");

        // Single events from the table
        foreach (vecs[k]) begin
            mark;
            in_port = vecs[k].in_val;
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                tick;
                if (evt_bus.evt_valid) begin lat = c; break; end
            end
            check($sformatf("vec%0d_lat", k), 64'(lat), 64'(vecs[k].exp_lat));
            check($sformatf("vec%0d_data", k), 64'(evt_bus.evt_data), 64'(vecs[k].exp_data));
            tick;
            check($sformatf("vec%0d_popped", k), 64'(evt_bus.evt_valid), 64'd0);
            check($sformatf("vec%0d_irq", k), 64'(pio_irq), 64'd0);
            exp_log.delete();
            exp_log.push_back(enc(1'b0, 2'd3, 32'h0));
            exp_log.push_back(enc(1'b1, 2'd3, 32'hF));
            exp_log.push_back(enc(1'b0, 2'd0, 32'h0));
            check_log($sformatf("vec%0d_bus", k));
            in_port = 4'h0;
            tick;
            tick;
        end

        // cfg_load during a sequence: last value wins, applied after the push
        mark;
        in_port = 4'h1;
        for (int n = 0; n < 40 && !busy; n++) tick;
        cfg_mask = 4'h4;
        cfg_load = 1'b1;
        tick;
        cfg_mask = 4'h2;
        tick;
        cfg_load = 1'b0;
        for (int n = 0; n < 40 && !evt_bus.evt_valid; n++) tick;
        check("load_evt", 64'(evt_bus.evt_data), 64'h11);
        repeat (6) tick;
        exp_log.delete();
        exp_log.push_back(enc(1'b0, 2'd3, 32'h0));
        exp_log.push_back(enc(1'b1, 2'd3, 32'hF));
        exp_log.push_back(enc(1'b0, 2'd0, 32'h0));
        exp_log.push_back(enc(1'b1, 2'd2, 32'h2));
        check_log("load_bus");
        in_port = 4'h0;
        tick;
        tick;
        mark;
        in_port = 4'h1;
        irq_seen = 1'b0;
        repeat (15) begin
            tick;
            if (pio_irq) irq_seen = 1'b1;
        end
        check("masked_irq", 64'(irq_seen), 64'd0);
        check("masked_valid", 64'(evt_bus.evt_valid), 64'd0);
        exp_log.delete();
        check_log("masked_bus");

        // Overflow, simultaneous pop+push when full, saturation, drain order
        do_reset("ovf_reset");
        evt_bus.evt_ready = 1'b0;
        all_ok = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            one_event(4'(v), ok);
            all_ok &= ok;
        end
        check("ovf_events_done", 64'(all_ok), 64'd1);
        check("ovf_count2", 64'(ovf_count), 64'd2);
        check("ovf_valid", 64'(evt_bus.evt_valid), 64'd1);
        in_port = 4'h5;
        repeat (7) tick;
        evt_bus.evt_ready = 1'b1;
        tick;
        evt_bus.evt_ready = 1'b0;
        check("full_pop_ovf", 64'(ovf_count), 64'd3);
        check("full_pop_head", 64'(evt_bus.evt_data), 64'h22);
        for (int n = 0; n < 40 && busy; n++) tick;
        in_port = 4'h0;
        tick;
        tick;
        all_ok = 1'b1;
        repeat (256) begin
            one_event(4'h9, ok);
            all_ok &= ok;
        end
        check("sat_events_done", 64'(all_ok), 64'd1);
        check("ovf_saturate", 64'(ovf_count), 64'd255);
        evt_bus.evt_ready = 1'b1;
        exp_log.delete();
        exp_log.push_back(36'h22);
        exp_log.push_back(36'h33);
        exp_log.push_back(36'h44);
        exp_log.push_back(36'h99);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), 64'(evt_bus.evt_valid), 64'd1);
            check($sformatf("drain%0d_data", i), 64'(evt_bus.evt_data), 64'(exp_log[i]));
            tick;
        end
        check("drain_empty", 64'(evt_bus.evt_valid), 64'd0);

        // Spurious interrupt: captured edge outside the mask
        do_reset("spur_reset");
        mark;
        cfg_mask = 4'h7;
        cfg_load = 1'b1;
        tick;
        cfg_load = 1'b0;
        repeat (4) tick;
        exp_log.delete();
        exp_log.push_back(enc(1'b1, 2'd2, 32'h7));
        check_log("spur_mask");
        mark;
        in_port = 4'h8;
        repeat (3) tick;
        check("spur_no_irq", 64'(pio_irq), 64'd0);
        irq_force = 1'b1;
        tick;
        irq_force = 1'b0;
        repeat (12) tick;
        exp_log.delete();
        exp_log.push_back(enc(1'b0, 2'd3, 32'h0));
        check_log("spur_bus");
        check("spur_valid", 64'(evt_bus.evt_valid), 64'd0);
        check("spur_busy", 64'(busy), 64'd0);

        // Reset in CLR_EDGE with two events queued
        do_reset("mid_reset");
        evt_bus.evt_ready = 1'b0;
        one_event(4'h1, ok);
        all_ok = ok;
        one_event(4'h2, ok);
        all_ok &= ok;
        check("mid_events_done", 64'(all_ok), 64'd1);
        check("mid_queued", 64'(evt_bus.evt_valid), 64'd1);
        in_port = 4'h3;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (pio_chipselect && !pio_write_n && pio_address == 2'd3) begin ok = 1'b1; break; end
        end
        check("mid_reached_clr", 64'(ok), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(evt_bus.evt_valid), 64'd0);
        check("mid_rst_data", 64'(evt_bus.evt_data), 64'h0);
        check("mid_rst_ovf", 64'(ovf_count), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd1);
        check("mid_rst_cs", 64'(pio_chipselect), 64'd0);
        do_reset("mid_rerun");
        check("mid_after_valid", 64'(evt_bus.evt_valid), 64'd0);

        check("idle_bus_values", 64'(idle_bad), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
